// File: rtl/enc_pkg.sv
// Shared encoder constants plus the gearbox buffer entry format.
// Also provides the wrap-around adder used for ring-buffer pointers.
package enc_pkg;

    localparam int EGF_DIM     = 8;
    localparam int ENC_SYM     = 4;
    localparam int RSC_COD_LEN = 255;
    localparam int OUT_SYM     = 2;
    localparam int GBX_BUF_DEP = 16;

    typedef struct packed {
        logic [EGF_DIM-1:0] data;
        logic               sof;
        logic               eof;
    } gbx_entry_t;

    // Single-subtraction wrap; callers guarantee a < m and b <= m.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned m);
        int unsigned s;
        s = a + b;
        return (s >= m) ? s - m : s;
    endfunction

endpackage

// File: rtl/enc_gbx_tagger.sv
// Per-lane codeword position tagging (sof/eof) for one encoder beat,
// plus the next value of the codeword symbol counter.
module enc_gbx_tagger
    import enc_pkg::*;
#(
    parameter int ENC_SYM     = 4,
    parameter int RSC_COD_LEN = 255,
    parameter int CW_W        = $clog2(RSC_COD_LEN)
) (
    input  logic               in_start,
    input  logic [CW_W-1:0]    cw_cnt,
    output logic [ENC_SYM-1:0] sof,
    output logic [ENC_SYM-1:0] eof,
    output logic [CW_W-1:0]    cw_next
);

    localparam int SUM_W = $clog2(RSC_COD_LEN + ENC_SYM + 1);

    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] idx;
    logic [SUM_W-1:0] nxt;

    // base < RSC_COD_LEN, so a short beat needs at most one subtraction.
    function automatic logic [SUM_W-1:0] mod_len(input logic [SUM_W-1:0] s);
        if (ENC_SYM < RSC_COD_LEN)
            return (s >= SUM_W'(RSC_COD_LEN)) ? s - SUM_W'(RSC_COD_LEN) : s;
        else
            return s % SUM_W'(RSC_COD_LEN);
    endfunction

    always_comb begin
        base = in_start ? '0 : SUM_W'(cw_cnt);
        sof  = '0;
        eof  = '0;
        idx  = '0;
        for (int i = 0; i < ENC_SYM; i++) begin
            idx    = mod_len(base + SUM_W'(i));
            sof[i] = (idx == '0);
            eof[i] = (idx == SUM_W'(RSC_COD_LEN - 1));
        end
        nxt     = mod_len(base + SUM_W'(ENC_SYM));
        cw_next = CW_W'(nxt);
    end

endmodule

// File: rtl/enc_out_gearbox.sv
// Re-packs ENC_SYM-wide encoder beats into OUT_SYM-wide valid/ready beats
// with codeword framing; whole beats are dropped (sticky ovf) when full.
module enc_out_gearbox
    import enc_pkg::*;
#(
    parameter int EGF_DIM     = enc_pkg::EGF_DIM,
    parameter int ENC_SYM     = enc_pkg::ENC_SYM,
    parameter int OUT_SYM     = enc_pkg::OUT_SYM,
    parameter int RSC_COD_LEN = enc_pkg::RSC_COD_LEN,
    parameter int GBX_BUF_DEP = enc_pkg::GBX_BUF_DEP
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic                               in_start,
    input  logic [ENC_SYM*EGF_DIM-1:0]         enc_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_SYM*EGF_DIM-1:0]         out_data,
    output logic                               out_sop,
    output logic                               out_eop,
    output logic [$clog2(OUT_SYM+1)-1:0]       out_eop_lane,
    output logic                               ovf,
    input  logic                               ovf_clr,
    output logic [$clog2(GBX_BUF_DEP+1)-1:0]   fill
);

    localparam int PTR_W  = $clog2(GBX_BUF_DEP);
    localparam int FILL_W = $clog2(GBX_BUF_DEP + 1);
    localparam int CW_W   = $clog2(RSC_COD_LEN);
    localparam int LANE_W = $clog2(OUT_SYM + 1);

    if (EGF_DIM != enc_pkg::EGF_DIM) begin : g_bad_dim
        $error("EGF_DIM must match the shared entry format");
    end
    if (OUT_SYM < 1 || OUT_SYM > ENC_SYM) begin : g_bad_out
        $error("OUT_SYM must be in 1..ENC_SYM");
    end
    if (RSC_COD_LEN < 2 || RSC_COD_LEN < OUT_SYM) begin : g_bad_len
        $error("RSC_COD_LEN must be >= 2 and >= OUT_SYM");
    end
    if (GBX_BUF_DEP < ENC_SYM + OUT_SYM) begin : g_bad_dep
        $error("GBX_BUF_DEP must be >= ENC_SYM + OUT_SYM");
    end

    gbx_entry_t         mem_q [GBX_BUF_DEP];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [FILL_W-1:0]  fill_q;
    logic [CW_W-1:0]    cw_cnt_q;
    logic [CW_W-1:0]    cw_next;
    logic               ovf_q;
    logic [ENC_SYM-1:0] tag_sof;
    logic [ENC_SYM-1:0] tag_eof;
    logic [FILL_W:0]    free;
    logic               pop;
    logic               push;
    logic               drop;
    gbx_entry_t         ent;

    function automatic logic [PTR_W-1:0] ptr_at(input logic [PTR_W-1:0] p, input int unsigned off);
        return PTR_W'(wrap_add(32'(p), off, GBX_BUF_DEP));
    endfunction

    enc_gbx_tagger #(
        .ENC_SYM     (ENC_SYM),
        .RSC_COD_LEN (RSC_COD_LEN),
        .CW_W        (CW_W)
    ) u_tagger (
        .in_start (in_start),
        .cw_cnt   (cw_cnt_q),
        .sof      (tag_sof),
        .eof      (tag_eof),
        .cw_next  (cw_next)
    );

    assign out_valid = (fill_q >= FILL_W'(OUT_SYM));
    assign pop       = out_valid & out_ready;
    assign fill      = fill_q;
    assign ovf       = ovf_q;

    // Space freed by this cycle's pop counts, so a full buffer can still stream.
    always_comb begin
        free = (FILL_W+1)'(GBX_BUF_DEP) - {1'b0, fill_q} + (pop ? (FILL_W+1)'(OUT_SYM) : '0);
        push = in_valid && (free >= (FILL_W+1)'(ENC_SYM));
        drop = in_valid && !push;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cw_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (in_valid) cw_cnt_q <= cw_next;
            if (push) wr_ptr_q <= ptr_at(wr_ptr_q, ENC_SYM);
            if (pop) rd_ptr_q <= ptr_at(rd_ptr_q, OUT_SYM);
            fill_q <= fill_q + (push ? FILL_W'(ENC_SYM) : '0) - (pop ? FILL_W'(OUT_SYM) : '0);
            if (drop) ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < ENC_SYM; i++) begin
                mem_q[ptr_at(wr_ptr_q, i)] <= '{data: enc_data[i*EGF_DIM +: EGF_DIM],
                                                sof:  tag_sof[i],
                                                eof:  tag_eof[i]};
            end
        end
    end

    // Outputs are forced to zero while no beat is presented.
    always_comb begin
        out_data     = '0;
        out_sop      = 1'b0;
        out_eop      = 1'b0;
        out_eop_lane = '0;
        ent          = '0;
        if (out_valid) begin
            for (int j = 0; j < OUT_SYM; j++) begin
                ent = mem_q[ptr_at(rd_ptr_q, j)];
                out_data[j*EGF_DIM +: EGF_DIM] = ent.data;
                if (ent.eof) begin
                    out_eop      = 1'b1;
                    out_eop_lane = LANE_W'(j);
                end
            end
            out_sop = mem_q[rd_ptr_q].sof;
        end
    end

endmodule

// File: doc/enc_out_gearbox.md
Name: enc_out_gearbox

Overview:
- Downstream of the RS encoder top. Takes its ENC_SYM-symbol-per-cycle output stream and re-packs it into OUT_SYM-symbol beats under a valid/ready handshake.
- Marks codeword boundaries (start, end, end lane) for the serializer/link stage.
- The encoder cannot be back-pressured, so the block buffers symbols, drops whole input beats when full, and raises a sticky overflow flag.

Parameters:
- EGF_DIM, 8, bits per GF symbol
- ENC_SYM, 4, symbols per input beat
- OUT_SYM, 2, symbols per output beat; 1 <= OUT_SYM <= ENC_SYM
- RSC_COD_LEN, 255, symbols per codeword; must be >= 2
- GBX_BUF_DEP, 16, buffer depth in symbols; must be >= ENC_SYM + OUT_SYM

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  enc_data beat valid
- in_start  in  1  beat is first of an aligned stream; lane 0 is codeword symbol 0
- enc_data  in  ENC_SYM*EGF_DIM  encoder output; lane 0 in LSBs, lane 0 emitted first
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts
- out_data  out  OUT_SYM*EGF_DIM  output symbols; lane 0 in LSBs
- out_sop  out  1  out_data lane 0 is codeword symbol 0
- out_eop  out  1  beat contains codeword symbol RSC_COD_LEN-1
- out_eop_lane  out  $clog2(OUT_SYM+1)  lane of that symbol; 0 when out_eop=0
- ovf  out  1  sticky overflow
- ovf_clr  in  1  synchronous clear of ovf
- fill  out  $clog2(GBX_BUF_DEP+1)  symbols currently buffered

Behaviour:
- Interface: one clock domain, clk. Reset rst is asynchronous and active-high.
- Reset:
  - Buffer empty, fill=0, read/write pointers 0.
  - Codeword counter 0, ovf=0, out_valid=0.
  - out_sop/out_eop/out_eop_lane=0, out_data=0.
- Storage:
  - Circular symbol buffer of GBX_BUF_DEP entries.
  - Each entry holds {data[EGF_DIM], sof, eof}.
  - Pointers wrap modulo GBX_BUF_DEP; pointer arithmetic handles non-power-of-2 depths.
- Codeword counter cw_cnt:
  - Range 0..RSC_COD_LEN-1, advanced per accepted-or-dropped in_valid beat.
  - Lane i symbol index = (base + i) mod RSC_COD_LEN, with base = 0 if in_start else cw_cnt.
  - sof = (index==0); eof = (index==RSC_COD_LEN-1).
  - Next cw_cnt = (base + ENC_SYM) mod RSC_COD_LEN. The wrap is computed with at most one subtraction when ENC_SYM < RSC_COD_LEN; otherwise a general modulo.
  - in_valid=0: cw_cnt holds.
- Push, when in_valid=1:
  - pop = out_valid & out_ready.
  - free = GBX_BUF_DEP - fill + (pop ? OUT_SYM : 0).
  - If free >= ENC_SYM, write all ENC_SYM lanes.
  - Otherwise drop the entire beat and set ovf. cw_cnt still advances so later codewords stay aligned.
- Pop:
  - out_valid = (fill >= OUT_SYM); combinational from registered fill.
  - out_data / out_sop / out_eop / out_eop_lane are combinational from the OUT_SYM entries at the read pointer.
  - On pop, the read pointer advances by OUT_SYM.
- Stability: when out_valid=1 and out_ready=0, all outputs hold stable until accepted (AXI-style). A push never alters entries at the read side.
- Simultaneous push and pop: fill_next = fill + push*ENC_SYM - pop*OUT_SYM.
- Multiple eof in one output beat (only possible if OUT_SYM > RSC_COD_LEN): not supported; parameter check enforces RSC_COD_LEN >= OUT_SYM.
- Latency: input beat to first possible out_valid is 1 cycle (registered write, combinational read).
- ovf:
  - Set on drop.
  - ovf_clr clears it; set wins over clear in the same cycle.
  - ovf never blocks operation.
- Reset mid-operation: all buffered symbols are discarded immediately. The first beat after reset must carry in_start for correct framing. Without in_start, cw_cnt=0 is taken as the alignment.

Decomposition:
- Shared package encoder.vh / enc_pkg holds:
  - EGF_DIM, ENC_SYM, RSC_COD_LEN (already shared).
  - New OUT_SYM and GBX_BUF_DEP.
  - typedef GBX_ENTRY {logic [EGF_DIM-1:0] data; logic sof; logic eof;}.
- One natural sub-module: enc_gbx_tagger, the combinational per-lane index/sof/eof generation plus cw_cnt next-state.
- Buffer, pointers and handshake stay in the top.

Test Plan:
All scenarios use EGF_DIM=8, ENC_SYM=4, OUT_SYM=2, RSC_COD_LEN=6, GBX_BUF_DEP=16.
1. Reset release, in_valid=0, out_ready=1 -> out_valid=0, fill=0, ovf=0 for 10 cycles. Assert rst mid-stream with fill=6 -> fill=0 and out_valid=0 asynchronously.
2. in_start + in_valid with symbols 0x00..0x03, then 0x04..0x07, out_ready=1 ->
   - beats {00,01} sop=1
   - {02,03}
   - {04,05} eop=1 lane=1
   - {06,07} sop=1 (second codeword starts at symbol 0x06)
3. Continuous in_valid, out_ready=1 ->
   - fill grows by 2 per cycle and reaches 16.
   - Next beat dropped, ovf=1.
   - Subsequent sop/eop still fall on a 6-symbol grid relative to the in_start symbol.
4. out_valid=1 with out_ready=0 for 5 cycles -> out_data/out_sop/out_eop constant. Raise out_ready -> exactly one beat accepted per cycle, order preserved.
5. fill=12, push and pop in the same cycle -> beat accepted (free=6), fill=14, ovf stays 0. ovf_clr together with a drop -> ovf remains 1. ovf_clr alone -> ovf=0.
6. in_start asserted mid-codeword (cw_cnt=2) -> that beat's lane 0 tagged sof. The next codeword's eop arrives 6 symbols later.
